mixed_burst_packer: RTL and testbench
=====================================

Name: mixed_burst_packer

Overview:
Downstream stage of the two-channel mixer. Consumes the mixer's merged word stream (DOUT/oVALID/iREADY) and groups it into bursts of BURST_LEN words, marking the final word with oLAST for the DMA/readout stage. An idle timeout closes partial bursts, so a stalled channel never strands data. It also keeps counters of full and short bursts for status registers.

Parameters:
DATA_WIDTH, 64, word width (matches mixer output)
BURST_LEN, 16, words per full burst; legal range 2..65535
TIMEOUT, 1024, idle cycles before a partial burst is closed; 0 disables the timeout
CNT_WIDTH, 32, width of status counters

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
DIN  in  DATA_WIDTH  word from mixer DOUT
iVALID  in  1  mixer oVALID
oREADY  out  1  high = word on DIN is accepted this cycle; drives mixer iREADY
DOUT  out  DATA_WIDTH  burst word
oLAST  out  1  marks the final word of a burst; qualified by oVALID
oVALID  out  1  DOUT/oLAST valid
iREADY  in  1  downstream accepts
BURST_COUNT  out  CNT_WIDTH  bursts completed with a full BURST_LEN words
SHORT_COUNT  out  CNT_WIDTH  bursts closed by timeout

Behaviour:
- Storage: hold register H (data, hv, index idx 0..BURST_LEN-1) and output register O (DOUT, oLAST, oVALID).
- A word is delayed in H until its LAST status is known; DIN→DOUT minimum latency is 2 cycles.
- o_free = !oVALID | iREADY.
- H→O move ("mv") happens when hv & o_free & (acc | idx==BURST_LEN-1 | tmo).
  - oLAST loaded as (idx==BURST_LEN-1) | (tmo & !acc).
- oREADY = !hv | mv_nolast_possible, where mv_nolast_possible = o_free & hv. oREADY may combinationally depend on iREADY. acc = iVALID & oREADY.
- On acc: H ← DIN, hv=1.
  - idx ← 0 if H was empty after a LAST or the moved word was LAST; otherwise idx ← idx+1.
  - Simultaneous acc and mv in the same cycle is legal and loses no word.
- idx==BURST_LEN-1 in H: H moves out with oLAST=1 as soon as o_free, without waiting for a successor.
- O register: oVALID set on mv; cleared on oVALID & iREADY & !mv. DOUT/oLAST stable while oVALID & !iREADY.
- Idle timer: counts cycles with hv & !acc and clears on acc or mv.
  - tmo = (TIMEOUT!=0) & (timer==TIMEOUT-1). Timer saturates there until the flush moves.
- Acceptance while tmo is asserted: the word is not LAST. H moves with oLAST=0, and the new word continues the burst.
- Counters increment on oVALID & iREADY & oLAST.
  - BURST_COUNT increments if the burst reached BURST_LEN words; otherwise SHORT_COUNT increments.
  - A per-O flag "short" is stored with oLAST.
  - Counters wrap modulo 2^CNT_WIDTH.
- Reset (RESET=0, asynchronous): oVALID=0, oLAST=0, DOUT=0, oREADY=0 while asserted, hv=0, idx=0, timer=0, counters=0.
  - Mid-burst reset discards H and O contents. The first word after release starts a new burst at idx 0.
  - oREADY=1 on the first cycle after release.
- Downstream backpressure: with O full and iREADY=0, H holds, oREADY=0, and no words are dropped. The timer runs, but tmo cannot move H until o_free.

Decomposition:
- Package mixed_burst_pkg: default DATA_WIDTH/BURST_LEN/TIMEOUT/CNT_WIDTH constants, and an index-width function clog2(BURST_LEN).
- Sub-module packer_idle_timer: inputs arm (hv & !acc) and clear (acc|mv); output tmo; handles the TIMEOUT=0 disable.
- All other logic stays in one module.

Test Plan:
- Stream 32 words 0..31 continuously, iREADY=1, BURST_LEN=16 → oLAST on words 15 and 31 only; BURST_COUNT=2; SHORT_COUNT=0; no gaps after a 2-cycle fill.
- Send 5 words, then idle, with TIMEOUT=8 → word 4 appears with oLAST=1 about 8 cycles after the last accept; SHORT_COUNT=1. Next word sent starts at idx 0.
- Send 16 words with iREADY toggling 1/0 each cycle → DOUT stable while stalled; all 16 words delivered in order; word 15 has oLAST=1; oREADY never accepts into an occupied, non-moving H.
- Send a word on exactly the cycle tmo asserts (TIMEOUT=8, 3 prior words) → no oLAST on word 2; burst continues; the later full burst counts in BURST_COUNT.
- Assert RESET low after 7 words of a burst, with O stalled by iREADY=0 → oVALID=0 immediately and counters=0. Post-release, 16 new words produce one burst, oLAST on the 16th.
- TIMEOUT=0, send 3 words, idle for 5000 cycles → word 2 stays in H, oVALID stays low for word 2, and no flush occurs.

Source files
------------

// File: rtl/mixed_burst_pkg.sv
// Shared defaults and width helper for the mixer burst packer.
package mixed_burst_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_CNT_WIDTH  = 32;

  // Bits needed to index 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle timer for the burst packer: counts held-word idle cycles, flags the flush point.
module packer_idle_timer
  import mixed_burst_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic arm,
  input  logic clear,
  output logic tmo
);

  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  logic [TW-1:0] timer;

  // Saturates at the terminal count so tmo stays up until the flush actually moves.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (arm && (timer != TERM)) begin
      timer <= timer + 1'b1;
    end
  end

  assign tmo = (TIMEOUT != 0) && (timer == TERM);

endmodule

// File: rtl/mixed_burst_packer.sv
// Groups the mixer word stream into BURST_LEN bursts tagged with oLAST; idle timeout closes short bursts.
module mixed_burst_packer
  import mixed_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  iVALID,
  output logic                  oREADY,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  oLAST,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic [CNT_WIDTH-1:0]  BURST_COUNT,
  output logic [CNT_WIDTH-1:0]  SHORT_COUNT
);

  localparam int IW = clog2(BURST_LEN);
  localparam logic [IW-1:0] IDX_END = IW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] h_data;
  logic                  hv;
  logic [IW-1:0]         idx;
  logic                  o_short;

  logic o_free;
  logic at_end;
  logic tmo;
  logic acc;
  logic mv;
  logic mv_last;

  assign o_free  = !oVALID || iREADY;
  assign at_end  = (idx == IDX_END);
  assign oREADY  = RESET && (!hv || o_free);
  assign acc     = iVALID && oREADY;
  assign mv      = hv && o_free && (acc || at_end || tmo);
  // A word arriving on the timeout cycle keeps the burst open.
  assign mv_last = at_end || (tmo && !acc);

  packer_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk_sys(CLK),
    .rst_b  (RESET),
    .arm    (hv && !acc),
    .clear  (acc || mv),
    .tmo    (tmo)
  );

  // H only ever empties after a LAST or reset, so an empty H always starts a new burst.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h_data <= '0;
      hv     <= 1'b0;
      idx    <= '0;
    end else if (acc) begin
      h_data <= DIN;
      hv     <= 1'b1;
      idx    <= (!hv || at_end) ? '0 : idx + 1'b1;
    end else if (mv) begin
      hv     <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      oVALID  <= 1'b0;
      oLAST   <= 1'b0;
      DOUT    <= '0;
      o_short <= 1'b0;
    end else if (mv) begin
      oVALID  <= 1'b1;
      oLAST   <= mv_last;
      DOUT    <= h_data;
      o_short <= !at_end;
    end else if (iREADY) begin
      oVALID  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BURST_COUNT <= '0;
      SHORT_COUNT <= '0;
    end else if (oVALID && iREADY && oLAST) begin
      if (o_short) SHORT_COUNT <= SHORT_COUNT + 1'b1;
      else         BURST_COUNT <= BURST_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_mixed_burst_packer.sv
// Bench for mixed_burst_packer: two instances (TIMEOUT=8 and TIMEOUT=0) checked against a queue-level model.
module tb_mixed_burst_packer;

  localparam int DW   = 32;
  localparam int BL   = 16;
  localparam int CW   = 16;
  localparam int TO_A = 8;

  logic          CLK    = 1'b0;
  logic          RESET  = 1'b0;
  logic [DW-1:0] DIN    = '0;
  logic          iVALID = 1'b0;
  logic          iREADY = 1'b1;

  logic          rdy_d   [2];
  logic          last_d  [2];
  logic          valid_d [2];
  logic [DW-1:0] dout_d  [2];
  logic [CW-1:0] bc_d    [2];
  logic [CW-1:0] sc_d    [2];

  mixed_burst_packer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO_A), .CNT_WIDTH(CW)) dut_a (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .iVALID(iVALID), .oREADY(rdy_d[0]),
    .DOUT(dout_d[0]), .oLAST(last_d[0]), .oVALID(valid_d[0]), .iREADY(iREADY),
    .BURST_COUNT(bc_d[0]), .SHORT_COUNT(sc_d[0]));

  mixed_burst_packer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(0), .CNT_WIDTH(CW)) dut_b (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .iVALID(iVALID), .oREADY(rdy_d[1]),
    .DOUT(dout_d[1]), .oLAST(last_d[1]), .oVALID(valid_d[1]), .iREADY(iREADY),
    .BURST_COUNT(bc_d[1]), .SHORT_COUNT(sc_d[1]));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  // Model: a held word remembers its position in the burst and the cycle it was loaded.
  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  longint        cyc = 0;
  bit            m_hv   [2];
  logic [DW-1:0] m_hd   [2];
  int            m_hpos [2];
  longint        m_ht   [2];
  bit            m_ov   [2];
  bit            m_ol   [2];
  bit            m_os   [2];
  logic [DW-1:0] m_od   [2];
  int            m_bc   [2];
  int            m_sc   [2];
  beat_t         log_a[$];
  beat_t         log_b[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hv[k] = 0; m_hd[k] = '0; m_hpos[k] = 0; m_ht[k] = 0;
      m_ov[k] = 0; m_ol[k] = 0; m_os[k] = 0; m_od[k] = '0;
      m_bc[k] = 0; m_sc[k] = 0;
    end
    log_a.delete();
    log_b.delete();
  endtask

  task automatic model_step(input int k, input bit ivalid, input logic [DW-1:0] din, input bit irdy);
    int    tmo_cfg;
    bit    o_free, rdy, acc, full, flush, mv, last_new;
    beat_t b;
    tmo_cfg  = (k == 0) ? TO_A : 0;
    o_free   = !m_ov[k] || irdy;
    rdy      = !m_hv[k] || o_free;
    acc      = ivalid && rdy;
    full     = m_hv[k] && (m_hpos[k] == BL - 1);
    flush    = (tmo_cfg != 0) && m_hv[k] && ((cyc - m_ht[k]) >= tmo_cfg);
    mv       = m_hv[k] && o_free && (acc || full || flush);
    last_new = full || (flush && !acc);
    if (m_ov[k] && irdy) begin
      b.data = m_od[k];
      b.last = m_ol[k];
      if (k == 0) log_a.push_back(b);
      else        log_b.push_back(b);
      if (m_ol[k]) begin
        if (m_os[k]) m_sc[k]++;
        else         m_bc[k]++;
      end
    end
    if (mv) begin
      m_od[k] = m_hd[k]; m_ol[k] = last_new; m_os[k] = !full; m_ov[k] = 1;
    end else if (m_ov[k] && irdy) begin
      m_ov[k] = 0;
    end
    if (acc) begin
      m_hpos[k] = (!m_hv[k] || last_new) ? 0 : m_hpos[k] + 1;
      m_hd[k]   = din;
      m_hv[k]   = 1;
      m_ht[k]   = cyc;
    end else if (mv) begin
      m_hv[k] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) model_reset();
      else begin
        cyc++;
        model_step(0, iVALID, DIN, iREADY);
        model_step(1, iVALID, DIN, iREADY);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        check("oREADY", k, rdy_d[k], RESET && (!m_hv[k] || !m_ov[k] || iREADY));
        check("oVALID", k, valid_d[k], m_ov[k]);
        if (m_ov[k]) begin
          check("DOUT", k, dout_d[k], m_od[k]);
          check("oLAST", k, last_d[k], m_ol[k]);
        end
        check("BURST_COUNT", k, bc_d[k], CW'(m_bc[k]));
        check("SHORT_COUNT", k, sc_d[k], CW'(m_sc[k]));
      end
    end
  end

  longint first_v = -1;
  longint last_v  = -1;
  initial begin
    forever begin
      @(negedge CLK);
      if (valid_d[0]) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
    end
  end

  bit tog_en = 0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (tog_en) iREADY = !iREADY;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      iVALID = 1'b1;
      DIN    = DW'(base + i);
      @(posedge CLK);
      #1;
    end
    iVALID = 1'b0;
  endtask

  task automatic send_hs(input int d);
    int budget;
    budget = 0;
    iVALID = 1'b1;
    DIN    = DW'(d);
    @(negedge CLK);
    while (!rdy_d[0] && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    check("send_wait", 0, budget < 100, 1);
    @(posedge CLK);
    #1;
    iVALID = 1'b0;
  endtask

  initial begin
    int     base, bb, n, lasts;
    longint c0;

    // Reset values
    idle(3);
    check("rst_oREADY", 0, rdy_d[0], 0);
    check("rst_oVALID", 0, valid_d[0], 0);
    check("rst_BURST", 0, bc_d[0], 0);
    check("rst_SHORT", 0, sc_d[0], 0);
    RESET = 1'b1;
    #1;
    check("release_oREADY", 0, rdy_d[0], 1);

    // Continuous stream of 32 words
    first_v = -1;
    c0 = cyc;
    stream(32, 0);
    idle(4);
    check("t1_beats", 0, log_a.size(), 32);
    for (int i = 0; i < 32; i++) begin
      check("t1_data", 0, log_a[i].data, i);
      check("t1_last", 0, log_a[i].last, (i == 15) || (i == 31));
    end
    check("t1_latency", 0, first_v - c0, 2);
    check("t1_span", 0, last_v - first_v, 31);
    check("t1_BURST", 0, bc_d[0], 2);
    check("t1_SHORT", 0, sc_d[0], 0);
    check("t1_model_bc", 0, m_bc[0], 2);
    check("t1_BURST", 1, bc_d[1], 2);

    // Partial burst closed by timeout
    base = log_a.size();
    bb   = log_b.size();
    stream(5, 100);
    n = 0;
    while (!(valid_d[0] && dout_d[0] == 104) && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("t2_flush_delay", 0, n, 8);
    check("t2_flush_last", 0, last_d[0], 1);
    idle(4);
    check("t2_beats", 0, log_a.size() - base, 5);
    check("t2_last_data", 0, log_a[base + 4].data, 104);
    check("t2_last_flag", 0, log_a[base + 4].last, 1);
    check("t2_SHORT", 0, sc_d[0], 1);
    check("t2_model_sc", 0, m_sc[0], 1);
    check("t2_held", 1, log_b.size() - bb, 4);
    check("t2_no_flush", 1, valid_d[1], 0);

    // Full burst under toggling backpressure
    base = log_a.size();
    tog_en = 1;
    for (int i = 0; i < 16; i++) send_hs(200 + i);
    tog_en = 0;
    iREADY = 1'b1;
    idle(6);
    check("t3_beats", 0, log_a.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      check("t3_data", 0, log_a[base + i].data, 200 + i);
      check("t3_last", 0, log_a[base + i].last, i == 15);
    end
    check("t3_BURST", 0, bc_d[0], 3);

    // Word accepted exactly on the timeout cycle continues the burst
    base = log_a.size();
    stream(3, 300);
    idle(7);
    stream(13, 303);
    idle(6);
    check("t4_beats", 0, log_a.size() - base, 16);
    check("t4_w2_no_last", 0, log_a[base + 2].last, 0);
    check("t4_w15_last", 0, log_a[base + 15].last, 1);
    check("t4_w15_data", 0, log_a[base + 15].data, 315);
    check("t4_BURST", 0, bc_d[0], 4);
    check("t4_SHORT", 0, sc_d[0], 1);

    // Reset mid-burst with output stalled
    stream(7, 400);
    iREADY = 1'b0;
    idle(2);
    RESET = 1'b0;
    #1;
    check("t5_rst_oVALID", 0, valid_d[0], 0);
    check("t5_rst_oREADY", 0, rdy_d[0], 0);
    check("t5_rst_BURST", 0, bc_d[0], 0);
    check("t5_rst_SHORT", 0, sc_d[0], 0);
    check("t5_rst_oVALID", 1, valid_d[1], 0);
    idle(3);
    RESET  = 1'b1;
    iREADY = 1'b1;
    #1;
    check("t5_release_oREADY", 0, rdy_d[0], 1);
    stream(16, 500);
    idle(6);
    check("t5_beats", 0, log_a.size(), 16);
    lasts = 0;
    for (int i = 0; i < log_a.size(); i++) if (log_a[i].last) lasts++;
    check("t5_last_count", 0, lasts, 1);
    check("t5_first", 0, log_a[0].data, 500);
    check("t5_last_flag", 0, log_a[15].last, 1);
    check("t5_BURST", 0, bc_d[0], 1);
    check("t5_BURST", 1, bc_d[1], 1);
    check("t5_beats", 1, log_b.size(), 16);

    // Timeout disabled: the held word never flushes
    stream(3, 600);
    idle(5000);
    check("t6_oVALID", 1, valid_d[1], 0);
    check("t6_beats", 1, log_b.size(), 18);
    check("t6_last_out", 1, log_b[17].data, 601);
    check("t6_SHORT", 1, sc_d[1], 0);
    check("t6_BURST", 1, bc_d[1], 1);
    check("t6_SHORT", 0, sc_d[0], 1);
    check("t6_flushed", 0, log_a[18].data, 602);
    check("t6_flushed_last", 0, log_a[18].last, 1);

    // Randomized traffic with periodic idle gaps
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) >= 180) iVALID = 1'b0;
      else                  iVALID = ($urandom_range(0, 3) != 0);
      DIN    = $urandom;
      iREADY = ($urandom_range(0, 3) != 0);
      @(posedge CLK);
      #1;
    end
    iVALID = 1'b0;
    iREADY = 1'b1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
